alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter PRIO_FIXED, default 0: 0 = round-robin grant; 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid, req1_valid  input  1 each  requester n has an operation pending.
REQ-005 req0_ready, req1_ready  output  1 each  requester n's operation accepted this cycle when valid also high.
REQ-006 req0_op, req1_op  input  4 each  opcode: 0 pass, 1 negate, 2 add, 3 sub, 4 inc, 5 dec, 6 and, 7 or, 8 xor, 9 shr, 10 shl; 11-15 illegal.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  16 each  operands A and B.
REQ-008 alu_sel  output  11  one-hot ALU select, bit index equals opcode 0-10: passthrough, bnegate, add, sub, inc, dec, band, bor, bxor, shr, shl.
REQ-009 alu_bus1, alu_bus2  output  16 each  operands driven to the ALU.
REQ-010 alu_bus3  input  16  ALU result.
REQ-011 rsp_valid  output  1  response available; rsp_ready  input  1  consumer accepts.
REQ-012 rsp_id  output  1  requester index that owns the response.
REQ-013 rsp_data  output  16  result; rsp_zero, rsp_neg, rsp_err  output  1 each  flags.

Function
REQ-014 The FSM SHALL have three states: IDLE, DRIVE, RESP; IDLE->DRIVE on accept, DRIVE->RESP unconditionally after one cycle, RESP->IDLE when rsp_valid && rsp_ready.
REQ-015 reqN_ready SHALL be high only in IDLE, only for the granted requester, at most one high per cycle, and combinationally dependent on the valid inputs.
REQ-016 Grant, round-robin mode: single valid wins; both valid -> requester not granted last; last-grant register updates only on an accept.
REQ-017 Grant, PRIO_FIXED=1: requester 0 wins whenever req0_valid is high.
REQ-018 On accept, op, A, B and requester index SHALL be registered; requester inputs are ignored until the FSM next returns to IDLE.
REQ-019 In DRIVE, alu_bus1=A and alu_bus2=B, and alu_sel SHALL have exactly the bit for the op set, for exactly one cycle.
REQ-020 Outside DRIVE, alu_sel SHALL be 0 and alu_bus1/alu_bus2 SHALL be 0.
REQ-021 At the DRIVE->RESP edge, rsp_data SHALL capture alu_bus3 (16-bit, no widening, wrap-around as produced by the ALU); rsp_zero = (result==0); rsp_neg = result[15]; rsp_err = 0.
REQ-022 Illegal opcode (11-15): in DRIVE, alu_sel SHALL be 0; the response SHALL have rsp_data=0, rsp_err=1, rsp_zero=0, rsp_neg=0.
REQ-023 rsp_valid SHALL be high throughout RESP; rsp_data, rsp_id and the flags SHALL be held stable while rsp_valid && !rsp_ready (backpressure of any length).
REQ-024 Latency: accept at edge N -> alu_sel active in cycle N..N+1 -> rsp_valid high from edge N+2; minimum 3 cycles per operation.
REQ-025 Accept in the same cycle the FSM leaves RESP SHALL NOT occur; the next accept is earliest in the IDLE cycle following.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, and set to 0: alu_sel, alu_bus1, alu_bus2, rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_neg, rsp_err and both ready outputs.
REQ-027 Reset SHALL set last-grant to requester 1, so requester 0 wins the first contention.
REQ-028 Reset asserted in DRIVE or RESP SHALL abandon the operation with no response produced.

Verification
REQ-029 req0 add A=0x0003 B=0x0004, rsp_ready=1 -> alu_sel=0x004 for one cycle; rsp_data=0x0007, id=0, zero=0, neg=0, err=0; rsp_valid at N+2.
REQ-030 Both requesters valid for 4 operations, round-robin -> grants 0,1,0,1; with PRIO_FIXED=1 -> 0,0,0,0.
REQ-031 req1 sub A=0x0000 B=0x0001 -> rsp_data=0xFFFF, neg=1; then req1 xor A=B=0x1234 -> rsp_data=0x0000, zero=1.
REQ-032 req0 op=12 -> alu_sel stays 0 in all cycles; response err=1, data=0x0000.
REQ-033 rsp_ready held low 5 cycles -> response held stable, both ready outputs low; accept occurs only after the rsp_ready handshake.
REQ-034 rst_n pulsed low during DRIVE -> all outputs 0 immediately, no response produced; req0 is granted first afterwards.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared single-cycle ALU.
// Either round-robin or fixed-priority arbitration picks one requester.
// Its opcode and operands are captured and presented to the ALU for
// exactly one cycle. The result is then returned through a
// valid/ready response port.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    per-requester handshake (ready is combinational)
//   reqN_op, reqN_a, reqN_b    opcode (0-10 legal, 11-15 illegal) and operands
//   alu_sel                    one-hot ALU function select, bit index = opcode
//   alu_bus1, alu_bus2         operands to the ALU; alu_bus3 = ALU result
//   rsp_valid / rsp_ready      response handshake
//   rsp_id, rsp_data           owning requester and 16-bit result
//   rsp_zero, rsp_neg, rsp_err result flags
module alu_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic [10:0] alu_sel,
    output logic [15:0] alu_bus1,
    output logic [15:0] alu_bus2,
    input  logic [15:0] alu_bus3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_neg,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Opcodes 0-10 are implemented by the ALU; everything above is illegal.
    function automatic logic op_legal(input logic [3:0] op);
        return (op <= 4'd10);
    endfunction

    // Illegal opcodes map to an all-zero select so the ALU stays idle.
    function automatic logic [10:0] op_onehot(input logic [3:0] op);
        logic [10:0] sel;
        if (op_legal(op)) begin
            sel = 11'd1 << op;
        end else begin
            sel = 11'd0;
        end
        return sel;
    endfunction

    state_t      state_q, state_d;
    logic        last_q, last_d;          // requester granted on the last accept
    logic        id_q, id_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [10:0] alu_sel_q, alu_sel_d;
    logic [15:0] bus1_q, bus1_d;
    logic [15:0] bus2_q, bus2_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_neg_q, rsp_neg_d;
    logic        rsp_err_q, rsp_err_d;

    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic [3:0]  sel_op;
    logic [15:0] sel_a;
    logic [15:0] sel_b;

    // Arbitration and combinational ready outputs. Ready is masked by rst_n
    // so that both readies read 0 while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (PRIO_FIXED) begin
            gnt0 = req0_valid;
        end else begin
            // On contention, requester 0 wins only if requester 1 was granted last.
            gnt0 = req0_valid & (~req1_valid | last_q);
        end
        gnt1       = req1_valid & ~gnt0;
        req0_ready = rst_n & (state_q == ST_IDLE) & gnt0;
        req1_ready = rst_n & (state_q == ST_IDLE) & gnt1;
        accept     = (req0_ready & req0_valid) | (req1_ready & req1_valid);
        if (req1_ready) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
        end else begin
            sel_op = req0_op;
            sel_a  = req0_a;
            sel_b  = req0_b;
        end
    end

    // Next-state and datapath. ALU drive registers default to 0, so they are
    // only non-zero in the single DRIVE cycle that follows an accept.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_sel_d   = 11'd0;
        bus1_d      = 16'h0000;
        bus2_d      = 16'h0000;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_neg_d   = rsp_neg_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_DRIVE;
                    id_d      = req1_ready;
                    last_d    = req1_ready;
                    op_d      = sel_op;
                    a_d       = sel_a;
                    b_d       = sel_b;
                    alu_sel_d = op_onehot(sel_op);
                    bus1_d    = sel_a;
                    bus2_d    = sel_b;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                if (op_legal(op_q)) begin
                    rsp_data_d = alu_bus3;
                    rsp_zero_d = (alu_bus3 == 16'h0000);
                    rsp_neg_d  = alu_bus3[15];
                    rsp_err_d  = 1'b0;
                end else begin
                    rsp_data_d = 16'h0000;
                    rsp_zero_d = 1'b0;
                    rsp_neg_d  = 1'b0;
                    rsp_err_d  = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; last-grant resets to requester 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            op_q        <= 4'd0;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            alu_sel_q   <= 11'd0;
            bus1_q      <= 16'h0000;
            bus2_q      <= 16'h0000;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_zero_q  <= 1'b0;
            rsp_neg_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_sel_q   <= alu_sel_d;
            bus1_q      <= bus1_d;
            bus2_q      <= bus2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_neg_q   <= rsp_neg_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_sel   = alu_sel_q;
    assign alu_bus1  = bus1_q;
    assign alu_bus2  = bus2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_neg   = rsp_neg_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter.
// The bench plays the ALU: it decodes the one-hot select into a result.
// A cycle-level protocol model predicts the readies, the ALU drive and
// rsp_valid. Expected responses are queued on each modelled accept, and a
// separate monitor compares them whenever the DUT presents a response.
// A second instance with PRIO_FIXED=1 checks fixed-priority grants.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [10:0] alu_sel;
    logic [15:0] alu_bus1, alu_bus2, alu_bus3;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_neg, rsp_err;
    logic [15:0] rsp_data;

    // Fixed-priority instance signals
    logic        f_rst_n, f_v0, f_v1, f_r0, f_r1, f_rsp_valid, f_rsp_id, f_z, f_n, f_e;
    logic [10:0] f_sel;
    logic [15:0] f_bus1, f_bus2, f_bus3, f_data;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        id;
        logic [15:0] data;
        logic        z;
        logic        n;
        logic        e;
    } rsp_t;
    rsp_t sbq[$];
    logic got_ids[$];

    // Behavioural ALU as seen through the one-hot select (non-one-hot -> 0)
    function automatic logic [15:0] alu_fn(input logic [10:0] sel, input logic [15:0] a, input logic [15:0] b);
        case (sel)
            11'h001: return a;
            11'h002: return ~a;
            11'h004: return a + b;
            11'h008: return a - b;
            11'h010: return a + 16'd1;
            11'h020: return a - 16'd1;
            11'h040: return a & b;
            11'h080: return a | b;
            11'h100: return a ^ b;
            11'h200: return a >> b[3:0];
            11'h400: return a << b[3:0];
            default: return 16'h0000;
        endcase
    endfunction

    // Reference result from the opcode
    function automatic logic [15:0] ref_fn(input int op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            0: return a;
            1: return ~a;
            2: return a + b;
            3: return a - b;
            4: return a + 16'd1;
            5: return a - 16'd1;
            6: return a & b;
            7: return a | b;
            8: return a ^ b;
            9: return a >> b[3:0];
            10: return a << b[3:0];
            default: return 16'h0000;
        endcase
    endfunction

    always_comb alu_bus3 = alu_fn(alu_sel, alu_bus1, alu_bus2);
    always_comb f_bus3   = alu_fn(f_sel, f_bus1, f_bus2);

    alu_arbiter #(.PRIO_FIXED(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .alu_sel(alu_sel), .alu_bus1(alu_bus1), .alu_bus2(alu_bus2), .alu_bus3(alu_bus3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_err(rsp_err)
    );

    alu_arbiter #(.PRIO_FIXED(1'b1)) dut_fix (
        .clk(clk), .rst_n(f_rst_n),
        .req0_valid(f_v0), .req1_valid(f_v1),
        .req0_ready(f_r0), .req1_ready(f_r1),
        .req0_op(4'd2), .req1_op(4'd3),
        .req0_a(16'h0010), .req0_b(16'h0001), .req1_a(16'h0020), .req1_b(16'h0002),
        .alu_sel(f_sel), .alu_bus1(f_bus1), .alu_bus2(f_bus2), .alu_bus3(f_bus3),
        .rsp_valid(f_rsp_valid), .rsp_ready(1'b1), .rsp_id(f_rsp_id),
        .rsp_data(f_data), .rsp_zero(f_z), .rsp_neg(f_n), .rsp_err(f_e)
    );

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Protocol model: 0 = waiting for accept, 1 = ALU cycle, 2 = response pending
    int          ph = 0;
    logic        last_g = 1'b1;
    int          m_op = 0;
    logic [15:0] m_a = 16'h0000;
    logic [15:0] m_b = 16'h0000;
    int          acc_cnt = 0;

    task automatic model_reset();
        ph = 0;
        last_g = 1'b1;
        sbq.delete();
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model,
    // return 1 ns after the rising edge ready for new stimulus.
    task automatic step();
        logic g0, g1;
        logic [10:0] es;
        rsp_t e;
        @(negedge clk);
        g0 = 1'b0;
        g1 = 1'b0;
        if (ph == 0) begin
            g0 = req0_valid && (!req1_valid || last_g);
            g1 = req1_valid && !g0;
        end
        check("req0_ready", 64'(req0_ready), 64'(g0));
        check("req1_ready", 64'(req1_ready), 64'(g1));
        es = (ph == 1 && m_op < 11) ? 11'(1 << m_op) : 11'd0;
        check("alu_sel", 64'(alu_sel), 64'(es));
        check("alu_bus1", 64'(alu_bus1), 64'((ph == 1) ? m_a : 16'h0000));
        check("alu_bus2", 64'(alu_bus2), 64'((ph == 1) ? m_b : 16'h0000));
        check("rsp_valid", 64'(rsp_valid), 64'(ph == 2));
        if (ph == 0) begin
            if (g0 || g1) begin
                m_op = g1 ? int'(req1_op) : int'(req0_op);
                m_a  = g1 ? req1_a : req0_a;
                m_b  = g1 ? req1_b : req0_b;
                e.id   = g1;
                e.data = (m_op < 11) ? ref_fn(m_op, m_a, m_b) : 16'h0000;
                e.z    = (m_op < 11) && (e.data == 16'h0000);
                e.n    = (m_op < 11) && e.data[15];
                e.e    = (m_op >= 11);
                sbq.push_back(e);
                last_g = g1;
                acc_cnt++;
                ph = 1;
            end
        end else if (ph == 1) begin
            ph = 2;
        end else if (rsp_ready) begin
            ph = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: compares the head of the scoreboard whenever a
    // response is presented, and pops it on the handshake.
    rsp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sbq.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'(1'b0));
            end else begin
                mon_e = sbq[0];
                check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
                check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
                check("rsp_flags", 64'({rsp_zero, rsp_neg, rsp_err}), 64'({mon_e.z, mon_e.n, mon_e.e}));
                if (rsp_ready) begin
                    got_ids.push_back(rsp_id);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic set_req(input int n, input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        if (n == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_alu"}, 64'({alu_sel, alu_bus1, alu_bus2}), 64'd0);
        check({name, "_rsp"}, 64'({rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_neg, rsp_err, req0_ready, req1_ready}), 64'd0);
    endtask

    // Assert reset (asynchronously, mid-cycle), check outputs clear at once.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset");
        model_reset();
        set_req(0, 1'b0, 4'd0, 16'h0000, 16'h0000);
        set_req(1, 1'b0, 4'd0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_steps(input int n);
        set_req(0, 1'b0, 4'd0, 16'h0000, 16'h0000);
        set_req(1, 1'b0, 4'd0, 16'h0000, 16'h0000);
        for (int i = 0; i < n; i++) step();
    endtask

    // Fixed-priority instance: both requesters always valid, requester 0 must own every response.
    int   f_cnt = 0;
    logic f_done = 1'b0;
    initial begin
        f_rst_n = 1'b0; f_v0 = 1'b0; f_v1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        f_rst_n = 1'b1; f_v0 = 1'b1; f_v1 = 1'b1;
        for (int c = 0; c < 40 && f_cnt < 4; c++) begin
            @(negedge clk);
            if (f_rsp_valid) begin
                check("prio_fixed_id", 64'(f_rsp_id), 64'(1'b0));
                check("prio_fixed_data", 64'(f_data), 64'(16'h0011));
                f_cnt++;
            end
        end
        f_v0 = 1'b0; f_v1 = 1'b0;
        f_done = 1'b1;
    end

    initial begin
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 1'b0, 4'd0, 16'h0000, 16'h0000);
        set_req(1, 1'b0, 4'd0, 16'h0000, 16'h0000);
        #2;
        apply_reset();

        // Contention for 4 operations: round-robin must give 0,1,0,1
        got_ids.delete();
        acc_cnt = 0;
        set_req(0, 1'b1, 4'd2, 16'h0100, 16'h0001);
        set_req(1, 1'b1, 4'd8, 16'h00FF, 16'h000F);
        for (int c = 0; c < 40 && acc_cnt < 4; c++) step();
        idle_steps(4);
        check("rr_count", 64'(got_ids.size()), 64'd4);
        for (int i = 0; i < 4 && i < got_ids.size(); i++)
            check("rr_order", 64'(got_ids[i]), 64'(i % 2));

        // req0 add 3+4
        set_req(0, 1'b1, 4'd2, 16'h0003, 16'h0004);
        step();
        idle_steps(4);

        // req1 sub 0-1 then xor equal operands
        set_req(1, 1'b1, 4'd3, 16'h0000, 16'h0001);
        step();
        idle_steps(4);
        set_req(1, 1'b1, 4'd8, 16'h1234, 16'h1234);
        step();
        idle_steps(4);

        // illegal opcode
        set_req(0, 1'b1, 4'd12, 16'h5555, 16'hAAAA);
        step();
        idle_steps(4);

        // backpressure: 5 cycles of rsp_ready low with both requesters waiting
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'd10, 16'h0001, 16'h0004);
        set_req(1, 1'b1, 4'd5, 16'h0000, 16'h0000);
        for (int i = 0; i < 7; i++) step();
        rsp_ready = 1'b1;
        step();
        step();
        idle_steps(4);

        // reset during DRIVE abandons the operation
        set_req(1, 1'b1, 4'd4, 16'h7FFF, 16'h0000);
        step();
        set_req(0, 1'b1, 4'd0, 16'h0001, 16'h0000);
        apply_reset();
        set_req(0, 1'b1, 4'd7, 16'h00F0, 16'h000F);
        set_req(1, 1'b1, 4'd6, 16'hFFFF, 16'h00FF);
        #1;
        check("first_grant_after_reset", 64'({req0_ready, req1_ready}), 64'(2'b10));
        step();
        idle_steps(4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_req(0, ($urandom % 2) == 0, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
            set_req(1, ($urandom % 2) == 0, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
            rsp_ready = ($urandom % 3) != 0;
            step();
        end
        rsp_ready = 1'b1;
        idle_steps(5);
        check("drain_empty", 64'(sbq.size()), 64'd0);
        check("prio_fixed_done", 64'({f_done, 8'(f_cnt)}), 64'({1'b1, 8'd4}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
